// File: rtl/serial_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  serial_tx_sequencer - LSB-first serializer with valid/ready word intake.
//  Optional even-parity trailer when SERIAL_TX_PARITY_EN is defined.
//  Revision: 1.0
// ============================================================================
module serial_tx_sequencer #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_valid_i,
    input  logic [DATA_WIDTH-1:0]                 din_i,
    output logic                                  start_ready_o,
    input  logic                                  abort_i,
    output logic                                  sel_o,
    output logic                                  serial_out_o,
    output logic                                  serial_valid_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [$clog2(DATA_WIDTH+1)-1:0]       bit_cnt_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  sel_q, sel_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        sel_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                sel_d   = 1'b1;
                if (start_valid_i) begin
                    state_d = S_SHIFT;
                    shreg_d = din_i;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    sel_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^din_i;
`endif
                end
            end
            S_SHIFT: begin
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                if (cnt_q == c_LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = S_PARITY;
                    cnt_d   = cnt_q + c_ONE;
                    valid_d = 1'b1;
`else
                    // Counter holds at the last index so it never reads DATA_WIDTH.
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + c_ONE;
                    valid_d = 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                sel_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                sel_d   = 1'b1;
            end
        endcase

        // Abort cancels only an in-flight word; DONE is already committed.
        if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            sel_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            sel_q    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            sel_q    <= sel_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // The shift register LSB is the live bit, so serial_out is a decode of state.
`ifdef SERIAL_TX_PARITY_EN
    assign serial_out_o = ((state_q == S_SHIFT)  && shreg_q[0]) ||
                          ((state_q == S_PARITY) && parity_q);
`else
    assign serial_out_o = (state_q == S_SHIFT) && shreg_q[0];
`endif

    assign serial_valid_o = valid_q;
    assign done_o         = done_q;
    assign start_ready_o  = ready_q;
    assign busy_o         = busy_q;
    assign sel_o          = sel_q;
    assign bit_cnt_o      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_sequencer.sv
`default_nettype none
// Directed bench for serial_tx_sequencer (DATA_WIDTH=4); expectations follow
// SERIAL_TX_PARITY_EN when the bench is compiled with it.
module tb_serial_tx_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sv;
    logic [W-1:0] din;
    logic         ab;
    logic         rdy, sel, so, vld, bsy, dn;
    logic [2:0]   cnt;

    int n_checks = 0;
    int n_errors = 0;

    serial_tx_sequencer #(.DATA_WIDTH(W)) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .start_valid_i  (sv),
        .din_i          (din),
        .start_ready_o  (rdy),
        .abort_i        (ab),
        .sel_o          (sel),
        .serial_out_o   (so),
        .serial_valid_o (vld),
        .busy_o         (bsy),
        .done_o         (dn),
        .bit_cnt_o      (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sv;
        logic [W-1:0] din;
        logic         ab;
        logic         so;
        logic         vld;
        logic         dn;
        logic         rdy;
        logic         bsy;
        logic         sel;
        int           cnt;   // -1: not checked
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic s, logic [W-1:0] d, logic a, logic eso, logic ev,
                                logic ed, logic er, logic eb, logic es, int ec);
        vec_t v;
        v.sv = s; v.din = d; v.ab = a; v.so = eso; v.vld = ev; v.dn = ed;
        v.rdy = er; v.bsy = eb; v.sel = es; v.cnt = ec;
        vq.push_back(v);
    endfunction

    // Expected-state shorthands: inputs applied before the edge, outputs after it.
    function automatic void e_bit(logic s, logic [W-1:0] d, logic a, logic b, int k);
        add(s, d, a, b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, k);
    endfunction
    function automatic void e_done(logic s, logic [W-1:0] d, logic a);
        add(s, d, a, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    endfunction
    function automatic void e_idle(logic s, logic [W-1:0] d, logic a);
        add(s, d, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    endfunction
    function automatic void e_par(logic s, logic [W-1:0] d, logic p);
`ifdef SERIAL_TX_PARITY_EN
        add(s, d, 1'b0, p, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, W);
`else
        if (s === 1'bz || d === 'z || p === 1'bz) vq.push_back(vq[0]);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " serial_out"},   32'(so),  32'd0);
        chk({tag, " serial_valid"}, 32'(vld), 32'd0);
        chk({tag, " done"},         32'(dn),  32'd0);
        chk({tag, " busy"},         32'(bsy), 32'd0);
        chk({tag, " start_ready"},  32'(rdy), 32'd1);
        chk({tag, " sel"},          32'(sel), 32'd1);
        chk({tag, " bit_cnt"},      32'(cnt), 32'd0);
    endtask

    task automatic run_table();
        for (int i = 0; i < vq.size(); i++) begin
            sv  = vq[i].sv;
            din = vq[i].din;
            ab  = vq[i].ab;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d serial_out", i),   32'(so),  32'(vq[i].so));
            chk($sformatf("v%0d serial_valid", i), 32'(vld), 32'(vq[i].vld));
            chk($sformatf("v%0d done", i),         32'(dn),  32'(vq[i].dn));
            chk($sformatf("v%0d start_ready", i),  32'(rdy), 32'(vq[i].rdy));
            chk($sformatf("v%0d busy", i),         32'(bsy), 32'(vq[i].bsy));
            chk($sformatf("v%0d sel", i),          32'(sel), 32'(vq[i].sel));
            if (vq[i].cnt >= 0)
                chk($sformatf("v%0d bit_cnt", i), 32'(cnt), 32'(vq[i].cnt));
        end
        vq.delete();
        sv = 1'b0;
        ab = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sv = 1'b0; din = '0; ab = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Word 1011: bits 1,1,0,1; parity 1; din wiggles after the handshake.
        e_bit (1'b1, 4'b1011, 1'b0, 1'b1, 0);
        e_bit (1'b0, 4'b0110, 1'b0, 1'b1, 1);
        e_bit (1'b0, 4'b0110, 1'b0, 1'b0, 2);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b1, 3);
`ifdef SERIAL_TX_PARITY_EN
        e_par (1'b0, 4'b0000, 1'b1);
`endif
        e_done(1'b0, 4'b0000, 1'b0);
        e_idle(1'b0, 4'b0000, 1'b0);

        // Abort while bit_cnt=1, then abort+start together in IDLE, abort in DONE.
        e_bit (1'b1, 4'b0110, 1'b0, 1'b0, 0);
        e_bit (1'b0, 4'b0110, 1'b0, 1'b1, 1);
        e_idle(1'b0, 4'b0110, 1'b1);
        e_bit (1'b1, 4'b1100, 1'b1, 1'b0, 0);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b0, 1);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b1, 2);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b1, 3);
`ifdef SERIAL_TX_PARITY_EN
        e_par (1'b0, 4'b0000, 1'b0);
`endif
        e_done(1'b0, 4'b0000, 1'b0);
        e_idle(1'b0, 4'b0000, 1'b1);

        // start_valid held high: 0001 then 1000, each sent exactly once.
        e_bit (1'b1, 4'b0001, 1'b0, 1'b1, 0);
        e_bit (1'b1, 4'b1000, 1'b0, 1'b0, 1);
        e_bit (1'b1, 4'b1000, 1'b0, 1'b0, 2);
        e_bit (1'b1, 4'b1000, 1'b0, 1'b0, 3);
`ifdef SERIAL_TX_PARITY_EN
        e_par (1'b1, 4'b1000, 1'b1);
`endif
        e_done(1'b1, 4'b1000, 1'b0);
        e_idle(1'b1, 4'b1000, 1'b0);
        e_bit (1'b1, 4'b1000, 1'b0, 1'b0, 0);
        e_bit (1'b0, 4'b1000, 1'b0, 1'b0, 1);
        e_bit (1'b0, 4'b1000, 1'b0, 1'b0, 2);
        e_bit (1'b0, 4'b1000, 1'b0, 1'b1, 3);
`ifdef SERIAL_TX_PARITY_EN
        e_par (1'b0, 4'b1000, 1'b1);
`endif
        e_done(1'b0, 4'b1000, 1'b0);
        e_idle(1'b0, 4'b1000, 1'b0);
        run_table();

        // Asynchronous reset in the middle of a word.
        sv = 1'b1; din = 4'b1011;
        @(posedge clk); #1;
        sv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", 32'(bsy), 32'd1);
        chk("pre-reset bit_cnt", 32'(cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async reset");
        @(posedge clk); #1;
        rst = 1'b0;

        e_bit (1'b1, 4'b1011, 1'b0, 1'b1, 0);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b1, 1);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b0, 2);
        e_bit (1'b0, 4'b0000, 1'b0, 1'b1, 3);
`ifdef SERIAL_TX_PARITY_EN
        e_par (1'b0, 4'b0000, 1'b1);
`endif
        e_done(1'b0, 4'b0000, 1'b0);
        e_idle(1'b0, 4'b0000, 1'b0);
        run_table();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
